my_risc_core: RTL and testbench



---
 rtl/my_risc_pkg.sv | 55 +++++
 rtl/risc_mem.sv | 28 ++
 rtl/my_risc_core.sv | 167 ++++++++++++++++
 tb/tb_my_risc_core.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_risc_pkg.sv
// Shared definitions for the my_risc_core processor: ISA opcodes, field positions,
// FSM states and the instruction decode helper.
package my_risc_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned MEM_DEPTH = 128;
  localparam int unsigned NUM_REGS  = 8;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned IMM_BIT  = 11;
  localparam int unsigned RD_MSB   = 8;
  localparam int unsigned RD_LSB   = 6;
  localparam int unsigned IMM_MSB  = 5;
  localparam int unsigned IMM_LSB  = 1;
  localparam int unsigned RS_MSB   = 3;
  localparam int unsigned RS_LSB   = 1;
  localparam int unsigned HALT_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]        opcode;
    logic              imm_mode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [DATA_W-1:0] imm;
    logic              halt_bit;
  } instr_t;

  // imm5 is zero-extended to the full data width
  function automatic instr_t decode(input logic [DATA_W-1:0] ir);
    instr_t d;
    d.opcode   = ir[OPC_MSB:OPC_LSB];
    d.imm_mode = ir[IMM_BIT];
    d.rd       = ir[RD_MSB:RD_LSB];
    d.rs       = ir[RS_MSB:RS_LSB];
    d.imm      = {11'd0, ir[IMM_MSB:IMM_LSB]};
    d.halt_bit = ir[HALT_BIT];
    return d;
  endfunction

endpackage

// File: rtl/risc_mem.sv
// Unified 128 x 16 instruction/data memory: one synchronous write port and two
// asynchronous read ports (core side and host side). Contents are never reset.
module risc_mem
  import my_risc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/my_risc_core.sv
// Multi-cycle 16-bit RISC core (FETCH/EXEC per instruction) with a host access
// port sharing the unified memory. Register file and ALU are inline.
module my_risc_core
  import my_risc_pkg::*;
(
  input  logic              Iclk,
  input  logic              Ireset,
  input  logic              Istart,
  input  logic              Iwrb,
  input  logic              Iaccess,
  input  logic [ADDR_W-1:0] Iaddr,
  input  logic [DATA_W-1:0] Idata_in,
  output logic [DATA_W-1:0] Odata_out,
  output logic              O_done
);

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_done;

  instr_t            w_dec;
  logic              w_exec;
  logic              w_is_halt;
  logic              w_lw_reg;
  logic              w_sw;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_operand;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_core_rdata;
  logic [ADDR_W-1:0] w_core_raddr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Decode, operand select, ALU and core read-address select
  always_comb begin
    w_dec     = decode(r_ir);
    w_exec    = (r_state == ST_EXEC);
    w_rd_val  = r_regs[w_dec.rd];
    w_rs_val  = r_regs[w_dec.rs];
    w_is_halt = (w_dec.opcode == OP_HALT) && w_dec.halt_bit;
    w_lw_reg  = w_exec && (w_dec.opcode == OP_LW) && !w_dec.imm_mode;
    w_sw      = w_exec && (w_dec.opcode == OP_SW);
    if (w_dec.imm_mode) begin
      w_operand = w_dec.imm;
    end else begin
      w_operand = w_rs_val;
    end
    if (w_dec.opcode == OP_SUB) begin
      w_alu = w_rd_val - w_operand;
    end else begin
      w_alu = w_rd_val + w_operand;
    end
    // FETCH and the LW literal both read at PC; only register-mode LW redirects
    if (w_lw_reg) begin
      w_core_raddr = w_rs_val[ADDR_W-1:0];
    end else begin
      w_core_raddr = r_pc;
    end
  end

  // Memory write mux: the host owns the port whenever Iaccess is high
  always_comb begin
    if (Iaccess) begin
      w_mem_we    = !Iwrb;
      w_mem_waddr = Iaddr;
      w_mem_wdata = Idata_in;
    end else begin
      w_mem_we    = w_sw;
      w_mem_waddr = w_rs_val[ADDR_W-1:0];
      w_mem_wdata = w_rd_val;
    end
  end

  risc_mem u_mem (
    .i_clk     (Iclk),
    .i_we      (w_mem_we),
    .i_waddr   (w_mem_waddr),
    .i_wdata   (w_mem_wdata),
    .i_raddr_a (w_core_raddr),
    .o_rdata_a (w_core_rdata),
    .i_raddr_b (Iaddr),
    .o_rdata_b (Odata_out)
  );

  // FSM state register
  always_ff @(posedge Iclk) begin
    if (Ireset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; Istart only matters in IDLE and DONE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Istart) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_FETCH: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (w_is_halt) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // PC, IR, register file and done flag
  always_ff @(posedge Iclk) begin
    if (Ireset) begin
      r_pc   <= 7'd0;
      r_ir   <= 16'd0;
      r_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 16'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Istart) begin
            r_pc   <= 7'd0;
            r_done <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_ir <= w_core_rdata;
          r_pc <= r_pc + 7'd1;
        end
        ST_EXEC: begin
          case (w_dec.opcode)
            OP_HALT: begin
              if (w_dec.halt_bit) begin
                r_done <= 1'b1;
              end
            end
            OP_ADD, OP_SUB: r_regs[w_dec.rd] <= w_alu;
            OP_LW: begin
              r_regs[w_dec.rd] <= w_core_rdata;
              if (w_dec.imm_mode) begin
                r_pc <= r_pc + 7'd1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign O_done = r_done;

endmodule

// File: tb/tb_my_risc_core.sv
// Self-checking bench for my_risc_core: directed scenarios plus random programs
// checked against an instruction-level interpreter of the ISA.
module tb_my_risc_core;

  logic        Iclk = 1'b0;
  logic        Ireset = 1'b1;
  logic        Istart = 1'b0;
  logic        Iwrb = 1'b1;
  logic        Iaccess = 1'b0;
  logic [6:0]  Iaddr = 7'd0;
  logic [15:0] Idata_in = 16'd0;
  logic [15:0] Odata_out;
  logic        O_done;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_mem [128];
  logic [15:0] m_regs [8];
  logic [15:0] prog [$];

  my_risc_core dut (
    .Iclk(Iclk), .Ireset(Ireset), .Istart(Istart), .Iwrb(Iwrb), .Iaccess(Iaccess),
    .Iaddr(Iaddr), .Idata_in(Idata_in), .Odata_out(Odata_out), .O_done(O_done)
  );

  always #5 Iclk = ~Iclk;

  function automatic logic [15:0] enc_ri(input logic [3:0] op, input logic [2:0] rd, input logic [4:0] imm);
    return {op, 1'b1, 2'b00, rd, imm, 1'b0};
  endfunction

  function automatic logic [15:0] enc_rr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, 1'b0, 2'b00, rd, 2'b00, rs, 1'b0};
  endfunction

  task automatic tick();
    @(posedge Iclk);
    #1;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [15:0] d);
    @(negedge Iclk);
    Iaccess = 1'b1; Iwrb = 1'b0; Iaddr = a; Idata_in = d;
    tick();
    Iaccess = 1'b0; Iwrb = 1'b1;
    m_mem[a] = d;
    if (Ireset) for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
  endtask

  task automatic host_read(input logic [6:0] a, output logic [15:0] d);
    Iaddr = a;
    #1;
    d = Odata_out;
  endtask

  task automatic pulse_reset();
    @(negedge Iclk);
    Ireset = 1'b1;
    tick();
    Ireset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) host_write(7'(i), prog[i]);
  endtask

  // ISA-level interpreter over the shadow memory; returns instructions executed
  task automatic model_run(input bit suppress_sw, output int k);
    logic [6:0]  pc;
    logic [15:0] ir, opd;
    logic [3:0]  op;
    logic [2:0]  rd, rs;
    pc = 7'd0;
    k = 0;
    while (k < 1000) begin
      ir = m_mem[pc];
      pc = pc + 7'd1;
      k++;
      op = ir[15:12]; rd = ir[8:6]; rs = ir[3:1];
      if (op == 4'h0 && ir[0]) break;
      opd = ir[11] ? {11'd0, ir[5:1]} : m_regs[rs];
      if (op == 4'h1) m_regs[rd] = m_regs[rd] + opd;
      else if (op == 4'h2) m_regs[rd] = m_regs[rd] - opd;
      else if (op == 4'h7 && ir[11]) begin
        m_regs[rd] = m_mem[pc];
        pc = pc + 7'd1;
      end
      else if (op == 4'h7) m_regs[rd] = m_mem[m_regs[rs][6:0]];
      else if (op == 4'h8 && !suppress_sw) m_mem[m_regs[rs][6:0]] = m_regs[rd];
    end
  endtask

  // Pulse start, optionally re-pulse it mid-run, then wait for done with a cycle budget
  task automatic run_core(input string name, input int exp_cycles, input int poke_at);
    int  cyc;
    bit  seen;
    @(negedge Iclk);
    Istart = 1'b1;
    tick();
    Istart = 1'b0;
    tests++;
    if (O_done !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_low_after_start: got %b expected 0", name, O_done);
    end
    cyc = 0;
    seen = 1'b0;
    while (cyc < 300 && !seen) begin
      if (cyc == poke_at) Istart = 1'b1;
      tick();
      Istart = 1'b0;
      cyc++;
      if (O_done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: done not seen in %0d cycles", name, cyc);
    end else if (cyc != exp_cycles) begin
      fails++;
      $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, exp_cycles);
    end
  endtask

  task automatic compare_mem(input string name);
    logic [15:0] d;
    int shown = 0;
    for (int a = 0; a < 128; a++) begin
      host_read(7'(a), d);
      tests++;
      if (d !== m_mem[a]) begin
        fails++;
        if (shown < 4) $display("FAIL %s_mem[%0d]: got %h expected %h", name, a, d, m_mem[a]);
        shown++;
      end
    end
  endtask

  task automatic check_word(input string name, input logic [6:0] a, input logic [15:0] exp);
    logic [15:0] d;
    host_read(a, d);
    tests++;
    if (d !== exp) begin
      fails++;
      $display("FAIL %s: mem[%0d] got %h expected %h", name, a, d, exp);
    end
  endtask

  task automatic load_benchmark();
    prog = '{16'h78C0, 16'h0040, 16'h7106, 16'h18C2, 16'h7146, 16'h1148, 16'h18C2,
             16'h8146, 16'h7186, 16'h2188, 16'h18C2, 16'h8186, 16'h0001};
    load_prog();
  endtask

  // Stores R0..R6 to mem[100..106] via pointer R7
  task automatic run_dump(input string name);
    int k;
    prog = '{};
    prog.push_back(enc_ri(4'h7, 3'd7, 5'd0));
    prog.push_back(16'd100);
    for (int i = 0; i < 7; i++) begin
      prog.push_back(enc_rr(4'h8, 3'(i), 3'd7));
      prog.push_back(enc_ri(4'h1, 3'd7, 5'd1));
    end
    prog.push_back(16'h0001);
    load_prog();
    model_run(1'b0, k);
    run_core(name, 2 * k, -1);
    for (int i = 0; i < 7; i++) check_word({name, "_reg_zero"}, 7'(100 + i), 16'd0);
    compare_mem(name);
  endtask

  task automatic test_reset();
    Ireset = 1'b1;
    tick(); tick();
    tests++;
    if (O_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: got %b expected 0", O_done);
    end
    Ireset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    for (int a = 0; a < 128; a++) host_write(7'(a), 16'd0);
    run_dump("reset_dump");
  endtask

  task automatic test_host_rw();
    logic [15:0] d;
    host_write(7'd100, 16'hBEEF);
    Iwrb = 1'b1;
    host_read(7'd100, d);
    tests++;
    if (d !== 16'hBEEF) begin
      fails++;
      $display("FAIL host_readback: got %h expected beef", d);
    end
    host_write(7'd101, 16'h1234);
    check_word("host_neighbor", 7'd100, 16'hBEEF);
    check_word("host_second", 7'd101, 16'h1234);
  endtask

  task automatic test_benchmark();
    int k;
    load_benchmark();
    @(negedge Iclk);
    Ireset = 1'b1;
    host_write(7'd64, 16'd5);
    Ireset = 1'b0;
    host_write(7'd65, 16'd7);
    host_write(7'd66, 16'd0);
    host_write(7'd67, 16'd0);
    model_run(1'b0, k);
    run_core("bench", 2 * k, 3);
    tests++;
    if (2 * k >= 30) begin
      fails++;
      $display("FAIL bench_budget: got %0d expected below 30", 2 * k);
    end
    check_word("bench_sum", 7'd66, 16'd12);
    check_word("bench_diff", 7'd67, 16'd7);
    tick(); tick(); tick();
    tests++;
    if (O_done !== 1'b1) begin
      fails++;
      $display("FAIL bench_done_hold: got %b expected 1", O_done);
    end
    compare_mem("bench");
  endtask

  task automatic test_restart_in_done();
    int k;
    host_write(7'd66, 16'd0);
    host_write(7'd67, 16'd0);
    model_run(1'b0, k);
    run_core("restart", 2 * k, -1);
    check_word("restart_sum", 7'd66, 16'd12);
    check_word("restart_diff", 7'd67, 16'd7);
  endtask

  task automatic test_wrap();
    int k;
    prog = '{enc_ri(4'h7, 3'd1, 5'd0), 16'hFFFF, enc_ri(4'h1, 3'd1, 5'd1),
             enc_ri(4'h7, 3'd2, 5'd0), 16'h0000, enc_ri(4'h2, 3'd2, 5'd1),
             enc_ri(4'h7, 3'd7, 5'd0), 16'd80, enc_rr(4'h8, 3'd1, 3'd7),
             enc_ri(4'h1, 3'd7, 5'd1), enc_rr(4'h8, 3'd2, 3'd7), 16'h0001};
    load_prog();
    model_run(1'b0, k);
    run_core("wrap", 2 * k, -1);
    check_word("wrap_add", 7'd80, 16'h0000);
    check_word("wrap_sub", 7'd81, 16'hFFFF);
    compare_mem("wrap");
  endtask

  task automatic test_reset_midrun();
    int k;
    load_benchmark();
    host_write(7'd66, 16'h5555);
    host_write(7'd67, 16'h6666);
    @(negedge Iclk);
    Istart = 1'b1;
    tick();
    Istart = 1'b0;
    repeat (5) tick();
    Ireset = 1'b1;
    tick();
    Ireset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    tests++;
    if (O_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_done: got %b expected 0", O_done);
    end
    repeat (4) tick();
    tests++;
    if (O_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle_hold: got %b expected 0", O_done);
    end
    check_word("midrst_mem66", 7'd66, 16'h5555);
    check_word("midrst_mem67", 7'd67, 16'h6666);
    compare_mem("midrst");
    run_dump("midrst_dump");
    load_benchmark();
    model_run(1'b0, k);
    run_core("midrst_rerun", 2 * k, -1);
    check_word("midrst_rerun_sum", 7'd66, 16'd12);
    check_word("midrst_rerun_diff", 7'd67, 16'd7);
  endtask

  task automatic test_access_suppress();
    int k;
    host_write(7'd90, 16'hAAAA);
    prog = '{enc_ri(4'h7, 3'd1, 5'd0), 16'h1234, enc_ri(4'h7, 3'd2, 5'd0), 16'd90,
             enc_rr(4'h8, 3'd1, 3'd2), 16'h0001};
    load_prog();
    model_run(1'b1, k);
    @(negedge Iclk);
    Iaccess = 1'b1; Iwrb = 1'b1; Iaddr = 7'd90;
    run_core("access", 2 * k, -1);
    Iaccess = 1'b0;
    check_word("access_suppressed", 7'd90, 16'hAAAA);
    model_run(1'b0, k);
    run_core("access_off", 2 * k, -1);
    check_word("access_store", 7'd90, 16'h1234);
  endtask

  task automatic test_random();
    int k;
    logic [2:0]  rd, rs;
    logic [4:0]  imm;
    logic [3:0]  op;
    for (int it = 0; it < 6; it++) begin
      for (int a = 64; a < 128; a++) host_write(7'(a), 16'($urandom));
      prog = '{};
      prog.push_back(enc_ri(4'h7, 3'd7, 5'd0));
      prog.push_back(16'($urandom_range(64, 127)));
      for (int n = 0; n < int'($urandom_range(6, 20)); n++) begin
        rd  = 3'($urandom_range(0, 6));
        rs  = 3'($urandom_range(0, 7));
        imm = 5'($urandom);
        case ($urandom_range(0, 7))
          0: prog.push_back(enc_ri(4'h1, rd, imm));
          1: prog.push_back(enc_rr(4'h1, rd, rs));
          2: prog.push_back(enc_ri(4'h2, rd, imm));
          3: prog.push_back(enc_rr(4'h2, rd, rs));
          4: prog.push_back(enc_rr(4'h7, rd, 3'd7));
          5: prog.push_back(enc_rr(4'h8, 3'($urandom_range(0, 7)), 3'd7));
          6: begin
            prog.push_back(enc_ri(4'h7, rd, imm));
            prog.push_back(16'($urandom));
          end
          default: begin
            op = 4'($urandom_range(3, 6));
            prog.push_back({op, 12'($urandom)});
          end
        endcase
      end
      prog.push_back(16'h0001);
      load_prog();
      model_run(1'b0, k);
      run_core("random", 2 * k, -1);
      compare_mem("random");
    end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_benchmark();
    test_restart_in_done();
    test_wrap();
    test_reset_midrun();
    test_access_suppress();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
